// File: rtl/prm_edge_scan_ctrl.sv
// Sequences a bank of combinational PRM edge-obstacle checkers: feeds voxel codes one at a time,
// ORs the returned edge vectors into a blocked-edge accumulator, then streams it out in words.
module prm_edge_scan_ctrl #(
    parameter int CODE_W   = 15,
    parameter int NUM_EDGE = 512,
    parameter int CHK_LAT  = 0,
    parameter int OUT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vox_valid,
    output logic                vox_ready,
    input  logic [CODE_W-1:0]   vox_code,
    input  logic                vox_last,
    input  logic                abort,
    output logic [CODE_W-1:0]   chk_code,
    input  logic [NUM_EDGE-1:0] chk_mask,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OUT_W-1:0]    res_data,
    output logic                res_last,
    output logic                res_any,
    output logic                busy
);

    localparam int NUM_WORDS = NUM_EDGE / OUT_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [3:0]       LAT_INIT = 4'(CHK_LAT);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OUT
    } state_t;

    state_t              state, state_d;
    logic [CODE_W-1:0]   chk_code_d;
    logic                last_q, last_d;
    logic [3:0]          settle_cnt, settle_cnt_d;
    logic [NUM_EDGE-1:0] acc, acc_d;
    logic [IDX_W-1:0]    word_idx, word_idx_d;
    logic                frame_open, frame_open_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            chk_code   <= '0;
            last_q     <= 1'b0;
            settle_cnt <= '0;
            acc        <= '0;
            word_idx   <= '0;
            frame_open <= 1'b0;
        end else begin
            state      <= state_d;
            chk_code   <= chk_code_d;
            last_q     <= last_d;
            settle_cnt <= settle_cnt_d;
            acc        <= acc_d;
            word_idx   <= word_idx_d;
            frame_open <= frame_open_d;
        end
    end

    always_comb begin
        state_d      = state;
        chk_code_d   = chk_code;
        last_d       = last_q;
        settle_cnt_d = settle_cnt;
        acc_d        = acc;
        word_idx_d   = word_idx;
        frame_open_d = frame_open;

        case (state)
            IDLE: begin
                if (vox_valid) begin
                    chk_code_d   = vox_code;
                    last_d       = vox_last;
                    settle_cnt_d = LAT_INIT;
                    state_d      = SETTLE;
                    // The first voxel of a frame discards the previous frame's result
                    if (!frame_open) begin
                        acc_d        = '0;
                        frame_open_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    acc_d = acc | chk_mask;
                    if (last_q) begin
                        state_d    = OUT;
                        word_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt - 4'd1;
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (word_idx == LAST_IDX) begin
                        frame_open_d = 1'b0;
                        word_idx_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        word_idx_d = word_idx + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any accept or handshake decided above
        if (abort) begin
            state_d      = IDLE;
            chk_code_d   = chk_code;
            last_d       = last_q;
            settle_cnt_d = settle_cnt;
            acc_d        = '0;
            word_idx_d   = '0;
            frame_open_d = 1'b0;
        end
    end

    always_comb begin
        vox_ready = (state == IDLE);
        res_valid = (state == OUT);
        busy      = (state != IDLE);
        res_last  = (state == OUT) && (word_idx == LAST_IDX);
        res_any   = (state == OUT) && (|acc);
        res_data  = '0;
        if (state == OUT) begin
            res_data = acc[word_idx*OUT_W +: OUT_W];
        end
    end

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Directed bench for prm_edge_scan_ctrl: a 64-edge bank with CHK_LAT=0 driven by a code lookup
// model, plus a CHK_LAT=3 instance whose checker mask changes every cycle.
module tb_prm_edge_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cyc = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Instance with CHK_LAT = 0
    logic        vox_valid = 1'b0, vox_last = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [14:0] vox_code = '0;
    logic        vox_ready, res_valid, res_last, res_any, busy;
    logic [14:0] chk_code;
    logic [63:0] chk_mask;
    logic [31:0] res_data;

    // Instance with CHK_LAT = 3
    logic        vox_valid3 = 1'b0, vox_last3 = 1'b0, abort3 = 1'b0, res_ready3 = 1'b0;
    logic [14:0] vox_code3 = '0;
    logic        vox_ready3, res_valid3, res_last3, res_any3, busy3;
    logic [14:0] chk_code3;
    logic [63:0] chk_mask3;
    logic [31:0] res_data3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [63:0] edge_model(input logic [14:0] code);
        case (code)
            15'h1234:          return 64'h8000_0000_0000_0001;
            15'h0001, 15'h0003: return 64'h0000_0000_0000_000F;
            15'h0002:          return 64'h0000_0000_0000_00F0;
            15'h0010:          return 64'h0000_0000_0000_0100;
            15'h0011:          return 64'h0000_0200_0000_0000;
            15'h0020:          return 64'h0000_0000_0000_0002;
            15'h0030:          return 64'hDEAD_BEEF_0000_0001;
            default:           return 64'h0;
        endcase
    endfunction

    assign chk_mask  = edge_model(chk_code);
    assign chk_mask3 = 64'd1 << cyc[5:0];

    prm_edge_scan_ctrl #(.CODE_W(15), .NUM_EDGE(64), .CHK_LAT(0), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .vox_valid(vox_valid), .vox_ready(vox_ready),
        .vox_code(vox_code), .vox_last(vox_last), .abort(abort), .chk_code(chk_code),
        .chk_mask(chk_mask), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last), .res_any(res_any), .busy(busy)
    );

    prm_edge_scan_ctrl #(.CODE_W(15), .NUM_EDGE(64), .CHK_LAT(3), .OUT_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .vox_valid(vox_valid3), .vox_ready(vox_ready3),
        .vox_code(vox_code3), .vox_last(vox_last3), .abort(abort3), .chk_code(chk_code3),
        .chk_mask(chk_mask3), .res_valid(res_valid3), .res_ready(res_ready3),
        .res_data(res_data3), .res_last(res_last3), .res_any(res_any3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one voxel to the CHK_LAT=0 instance; returns the cycle in which it was accepted
    task automatic applyStimulus(input logic [14:0] code, input logic last, output int acc_cyc);
        int n = 0;
        vox_code  = code;
        vox_last  = last;
        vox_valid = 1'b1;
        while (!vox_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", 64'd0, 64'd1);
        acc_cyc = int'(cyc);
        tick();
        vox_valid = 1'b0;
    endtask

    // Drains a two-word readout with res_ready held high
    task automatic readFrame(input string tag, input logic [63:0] exp_mask);
        res_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            int n = 0;
            while (!res_valid && n < 50) begin
                tick();
                n++;
            end
            checkOutput($sformatf("%s_valid%0d", tag, w), 64'(res_valid), 64'd1);
            checkOutput($sformatf("%s_data%0d", tag, w), 64'(res_data),
                        (w == 0) ? {32'd0, exp_mask[31:0]} : {32'd0, exp_mask[63:32]});
            checkOutput($sformatf("%s_last%0d", tag, w), 64'(res_last), (w == 1) ? 64'd1 : 64'd0);
            checkOutput($sformatf("%s_any%0d", tag, w), 64'(res_any), 64'(|exp_mask));
            tick();
        end
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        int a1, a2, a3, n;
        logic [63:0] exp3;
        logic seen;

        // Reset values
        tick();
        tick();
        checkOutput("rst_vox_ready", 64'(vox_ready), 64'd1);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_res_last", 64'(res_last), 64'd0);
        checkOutput("rst_res_any", 64'(res_any), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_chk_code", 64'(chk_code), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single-voxel frame
        applyStimulus(15'h1234, 1'b1, a1);
        checkOutput("t1_chk_code", 64'(chk_code), 64'h1234);
        checkOutput("t1_ready_settle", 64'(vox_ready), 64'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("t1_ready_out", 64'(vox_ready), 64'd0);
        readFrame("t1", 64'h8000_0000_0000_0001);
        checkOutput("t1_busy_after", 64'(busy), 64'd0);

        // Three-voxel frame, duplicate mask
        applyStimulus(15'h0001, 1'b0, a1);
        checkOutput("t2_code1", 64'(chk_code), 64'h0001);
        applyStimulus(15'h0002, 1'b0, a2);
        checkOutput("t2_code2", 64'(chk_code), 64'h0002);
        checkOutput("t2_interval12", 64'(a2 - a1), 64'd2);
        applyStimulus(15'h0003, 1'b1, a3);
        checkOutput("t2_code3", 64'(chk_code), 64'h0003);
        checkOutput("t2_interval23", 64'(a3 - a2), 64'd2);
        readFrame("t2", 64'h0000_0000_0000_00FF);

        // CHK_LAT=3: capture uses the mask 4 cycles after accept
        vox_code3  = 15'h0001;
        vox_last3  = 1'b0;
        vox_valid3 = 1'b1;
        a1 = int'(cyc);
        tick();
        vox_code3 = 15'h0002;
        vox_last3 = 1'b1;
        n = 0;
        while (!vox_ready3 && n < 20) begin
            tick();
            n++;
        end
        a2 = int'(cyc);
        checkOutput("t3_interval", 64'(a2 - a1), 64'd5);
        tick();
        vox_valid3 = 1'b0;
        exp3 = (64'd1 << ((a1 + 4) % 64)) | (64'd1 << ((a2 + 4) % 64));
        res_ready3 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (!res_valid3 && n < 50) begin
                tick();
                n++;
            end
            checkOutput($sformatf("t3_data%0d", w), 64'(res_data3),
                        (w == 0) ? {32'd0, exp3[31:0]} : {32'd0, exp3[63:32]});
            checkOutput($sformatf("t3_last%0d", w), 64'(res_last3), (w == 1) ? 64'd1 : 64'd0);
            tick();
        end
        res_ready3 = 1'b0;
        checkOutput("t3_busy_after", 64'(busy3), 64'd0);

        // Readout backpressure, then a frame starting from a cleared accumulator
        applyStimulus(15'h0002, 1'b1, a1);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t4_hold_data%0d", i), 64'(res_data), 64'h0F0);
            checkOutput($sformatf("t4_hold_ready%0d", i), 64'(vox_ready), 64'd0);
            checkOutput($sformatf("t4_hold_last%0d", i), 64'(res_last), 64'd0);
            tick();
        end
        readFrame("t4", 64'h0000_0000_0000_00F0);
        checkOutput("t4_busy_after", 64'(busy), 64'd0);
        applyStimulus(15'h0000, 1'b1, a1);
        readFrame("t4b", 64'h0);

        // Abort during SETTLE of the second voxel
        applyStimulus(15'h0010, 1'b0, a1);
        applyStimulus(15'h0011, 1'b0, a2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | res_valid | busy;
            tick();
        end
        checkOutput("t5_no_result", 64'(seen), 64'd0);
        applyStimulus(15'h0020, 1'b1, a1);
        readFrame("t5", 64'h0000_0000_0000_0002);

        // Asynchronous reset in the middle of readout
        applyStimulus(15'h0030, 1'b1, a1);
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput("t6_word1_last", 64'(res_last), 64'd1);
        checkOutput("t6_word1_data", 64'(res_data), 64'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 64'(res_valid), 64'd0);
        checkOutput("t6_rst_last", 64'(res_last), 64'd0);
        checkOutput("t6_rst_any", 64'(res_any), 64'd0);
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_ready", 64'(vox_ready), 64'd1);
        checkOutput("t6_rst_code", 64'(chk_code), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        checkOutput("t6_post_ready", 64'(vox_ready), 64'd1);
        checkOutput("t6_post_valid", 64'(res_valid), 64'd0);
        applyStimulus(15'h0020, 1'b1, a1);
        readFrame("t6", 64'h0000_0000_0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
